// File: rtl/wb_pkg.sv
// Writeback sequencer shared definitions.
//   wb_state_t : sequencer FSM states
//   REG_PC     : register address reserved for the program counter (all ones)
//   wb_pkt_t   : captured packet control fields at the default geometry
package wb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wb_state_t;

   localparam int WB_ADDRESSWIDTH = 4;
   localparam int WB_LANES        = 4;

   localparam logic [WB_ADDRESSWIDTH-1:0] REG_PC = '1;

   typedef struct packed {
      logic                       isvector;
      logic [WB_ADDRESSWIDTH-1:0] addr;
      logic [WB_LANES-1:0]        mask;
   } wb_pkt_t;

endpackage

// File: rtl/wb_sequencer_lane_select.sv
// LANES:1 mux of WIDTH-bit words, indexed by the lane counter.
//   data : packed lanes, lane i at [i*WIDTH +: WIDTH]
//   sel  : lane index
//   y    : selected word
module lane_select #(
   parameter int WIDTH = 24,
   parameter int LANES = 4,
   parameter int LANEW = $clog2(LANES)
) (
   input  logic [LANES*WIDTH-1:0] data,
   input  logic [LANEW-1:0]       sel,
   output logic [WIDTH-1:0]       y
);

   always_comb begin
      y = '0;
      for (int i = 0; i < LANES; i++) begin
         if (sel == LANEW'(i)) y = data[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: captures scalar/vector results over valid/ready and
// serializes them into one register-file write per cycle.
//   clk, reset            : clock, async active-high reset
//   in_valid/in_ready     : upstream handshake
//   in_isvector/addr/data/mask : result packet
//   we3/wa3/wd3/isvector/lane  : register-file write port
//   busy                  : FSM not idle
//   pend_valid/addr/isvector   : destination still being written (RAW stall)
//   err_pc_write          : pulse when a scalar PC write is dropped
//
// state | meaning
// IDLE  | no packet held, ready to accept
// WRITE | issuing writes for the captured packet, one lane per cycle
module wb_sequencer
   import wb_pkg::*;
#(
   parameter int WIDTH        = 24,
   parameter int ADDRESSWIDTH = 4,
   parameter int LANES        = 4,
   parameter int LANEW        = $clog2(LANES)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_isvector,
   input  logic [ADDRESSWIDTH-1:0] in_addr,
   input  logic [LANES*WIDTH-1:0]  in_data,
   input  logic [LANES-1:0]        in_mask,
   output logic                    we3,
   output logic [ADDRESSWIDTH-1:0] wa3,
   output logic [WIDTH-1:0]        wd3,
   output logic                    isvector,
   output logic [LANEW-1:0]        lane,
   output logic                    busy,
   output logic                    pend_valid,
   output logic [ADDRESSWIDTH-1:0] pend_addr,
   output logic                    pend_isvector,
   output logic                    err_pc_write
);

   localparam logic [LANEW-1:0] LAST_LANE = LANEW'(LANES-1);

   wb_state_t               state, state_n;
   logic [LANEW-1:0]        cnt, cnt_n;
   logic                    pkt_isvector;
   logic [ADDRESSWIDTH-1:0] pkt_addr;
   logic [LANES*WIDTH-1:0]  pkt_data;
   logic [LANES-1:0]        pkt_mask;
   logic                    last_cycle, accept_ok, accept, pc_hit;

   assign last_cycle = (state == WRITE) && (!pkt_isvector || (cnt == LAST_LANE));
   assign accept_ok  = (state == IDLE) || last_cycle;
   assign accept     = in_valid && accept_ok;
   assign in_ready   = accept_ok && !reset;
   assign pc_hit     = &pkt_addr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         pkt_isvector <= 1'b0;
         pkt_addr     <= '0;
         pkt_data     <= '0;
         pkt_mask     <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            pkt_isvector <= in_isvector;
            pkt_addr     <= in_addr;
            pkt_data     <= in_data;
            pkt_mask     <= in_mask;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n = WRITE;
               cnt_n   = '0;
            end
         end
         WRITE: begin
            if (last_cycle) begin
               cnt_n = '0;
               if (!accept) state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      we3          = 1'b0;
      err_pc_write = 1'b0;
      if (state == WRITE) begin
         if (pkt_isvector) begin
            we3 = pkt_mask[cnt];
         end else if (pc_hit) begin
            err_pc_write = 1'b1;
         end else begin
            we3 = 1'b1;
         end
      end
   end

   lane_select #(
      .WIDTH (WIDTH),
      .LANES (LANES),
      .LANEW (LANEW)
   ) u_lane_select (
      .data (pkt_data),
      .sel  (cnt),
      .y    (wd3)
   );

   assign wa3           = pkt_addr;
   assign isvector      = pkt_isvector;
   assign lane          = cnt;
   assign busy          = (state == WRITE);
   assign pend_valid    = busy;
   assign pend_addr     = busy ? pkt_addr : '0;
   assign pend_isvector = busy && pkt_isvector;

endmodule

// File: tb/tb_wb_sequencer.sv
module tb_wb_sequencer;

   localparam int W  = 24;
   localparam int AW = 4;
   localparam int L  = 4;
   localparam int LW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          in_isvector = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic [L*W-1:0] in_data = '0;
   logic [L-1:0]  in_mask = '0;
   logic          we3;
   logic [AW-1:0] wa3;
   logic [W-1:0]  wd3;
   logic          isvector;
   logic [LW-1:0] lane;
   logic          busy;
   logic          pend_valid;
   logic [AW-1:0] pend_addr;
   logic          pend_isvector;
   logic          err_pc_write;

   int n_chk  = 0;
   int n_fail = 0;
   int late_writes = 0;
   int total_writes = 0;

   always #5 clk = ~clk;

   wb_sequencer #(.WIDTH(W), .ADDRESSWIDTH(AW), .LANES(L)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_isvector(in_isvector), .in_addr(in_addr),
      .in_data(in_data), .in_mask(in_mask),
      .we3(we3), .wa3(wa3), .wd3(wd3), .isvector(isvector), .lane(lane),
      .busy(busy), .pend_valid(pend_valid), .pend_addr(pend_addr),
      .pend_isvector(pend_isvector), .err_pc_write(err_pc_write)
   );

   // Writes committed by the register file happen at rising edges.
   always @(posedge clk) begin
      if (we3) total_writes++;
      if (we3 && isvector && wa3 == 4'd2 && lane >= 2'd2) late_writes++;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] got;
      int base;
      @(negedge clk);
      n_chk++;
      got = {in_ready, we3, wa3, wd3[2:0], isvector, lane, busy, pend_valid, pend_addr, pend_isvector, err_pc_write};
      if (got !== 32'd0 || wd3 !== 24'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h wd3 %h required 0", got, wd3);
      end
      reset = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_isvector = 1'b1; in_addr = 4'd2; in_mask = 4'hF;
      in_data = {24'hD4, 24'hD3, 24'hD2, 24'hD1};
      tick();
      in_valid = 1'b0;
      tick();
      n_chk++;
      if ({we3, wa3, lane, wd3} !== {1'b1, 4'd2, 2'd1, 24'hD2}) begin
         n_fail++; $display("FAIL rst_lane1: got we3=%b wa3=%0d lane=%0d wd3=%h required 1 2 1 d2", we3, wa3, lane, wd3);
      end
      base = total_writes;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({in_ready, we3, busy, pend_valid, lane} !== 6'd0) begin
         n_fail++; $display("FAIL rst_during: got ready=%b we3=%b busy=%b pend=%b lane=%0d required 0", in_ready, we3, busy, pend_valid, lane);
      end
      tick();
      reset = 1'b0;
      #1;
      n_chk++;
      if ({in_ready, we3, wa3, wd3, isvector, lane, busy, pend_valid, pend_addr, pend_isvector, err_pc_write}
          !== {1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rst_release: got ready=%b we3=%b wa3=%0d wd3=%h vec=%b lane=%0d busy=%b required ready=1 rest 0",
                            in_ready, we3, wa3, wd3, isvector, lane, busy);
      end
      tick(); tick();
      n_chk++;
      if (late_writes !== 0 || total_writes !== base + 1) begin
         n_fail++; $display("FAIL rst_discard: got late=%0d writes=%0d required late=0 writes=%0d", late_writes, total_writes - base, 1);
      end
   endtask

   task automatic test_scalar();
      @(negedge clk);
      in_valid = 1'b1; in_isvector = 1'b0; in_addr = 4'd5; in_mask = 4'h0;
      in_data = {72'd0, 24'h00ABCD};
      n_chk++;
      if ({in_ready, busy} !== 2'b10) begin
         n_fail++; $display("FAIL scalar_idle: got ready=%b busy=%b required 1 0", in_ready, busy);
      end
      tick();
      in_valid = 1'b0;
      n_chk++;
      if ({we3, wa3, wd3, isvector, lane, err_pc_write} !== {1'b1, 4'd5, 24'h00ABCD, 1'b0, 2'd0, 1'b0}) begin
         n_fail++; $display("FAIL scalar_write: got we3=%b wa3=%0d wd3=%h vec=%b lane=%0d err=%b required 1 5 00abcd 0 0 0",
                            we3, wa3, wd3, isvector, lane, err_pc_write);
      end
      n_chk++;
      if ({busy, pend_valid, pend_addr, pend_isvector, in_ready} !== {1'b1, 1'b1, 4'd5, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL scalar_pend: got busy=%b pv=%b pa=%0d pvec=%b ready=%b required 1 1 5 0 1",
                            busy, pend_valid, pend_addr, pend_isvector, in_ready);
      end
      tick();
      n_chk++;
      if ({busy, pend_valid, we3, in_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL scalar_done: got busy=%b pv=%b we3=%b ready=%b required 0 0 0 1", busy, pend_valid, we3, in_ready);
      end
   endtask

   task automatic test_pc_protect();
      int base;
      @(negedge clk);
      in_valid = 1'b1; in_isvector = 1'b0; in_addr = 4'd15; in_data = {72'd0, 24'h123456};
      tick();
      in_valid = 1'b0;
      n_chk++;
      if ({we3, err_pc_write, busy} !== 3'b011) begin
         n_fail++; $display("FAIL pc_scalar: got we3=%b err=%b busy=%b required 0 1 1", we3, err_pc_write, busy);
      end
      tick();
      n_chk++;
      if ({we3, err_pc_write, busy} !== 3'b000) begin
         n_fail++; $display("FAIL pc_pulse_end: got we3=%b err=%b busy=%b required 0 0 0", we3, err_pc_write, busy);
      end
      base = total_writes;
      in_valid = 1'b1; in_isvector = 1'b1; in_addr = 4'd15; in_mask = 4'hF;
      in_data = {24'hF4, 24'hF3, 24'hF2, 24'hF1};
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < L; i++) begin
         n_chk++;
         if ({we3, err_pc_write, wa3, isvector, lane, wd3} !== {1'b1, 1'b0, 4'd15, 1'b1, LW'(i), 24'hF1 + 24'(i)}) begin
            n_fail++; $display("FAIL pc_vector lane %0d: got we3=%b err=%b wa3=%0d vec=%b lane=%0d wd3=%h required 1 0 15 1 %0d %h",
                               i, we3, err_pc_write, wa3, isvector, lane, wd3, i, 24'hF1 + 24'(i));
         end
         tick();
      end
      n_chk++;
      if (total_writes !== base + 4 || busy !== 1'b0) begin
         n_fail++; $display("FAIL pc_vector_count: got writes=%0d busy=%b required 4 0", total_writes - base, busy);
      end
   endtask

   task automatic test_vector_mask();
      logic [3:0] exp_we;
      exp_we = 4'b1010;
      @(negedge clk);
      in_valid = 1'b1; in_isvector = 1'b1; in_addr = 4'd3; in_mask = 4'b1010;
      in_data = {24'd4, 24'd3, 24'd2, 24'd1};
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < L; i++) begin
         n_chk++;
         if ({we3, wa3, wd3, isvector, lane} !== {exp_we[i], 4'd3, 24'(i + 1), 1'b1, LW'(i)}) begin
            n_fail++; $display("FAIL vec_lane %0d: got we3=%b wa3=%0d wd3=%0d vec=%b lane=%0d required %b 3 %0d 1 %0d",
                               i, we3, wa3, wd3, isvector, lane, exp_we[i], i + 1, i);
         end
         n_chk++;
         if ({pend_valid, pend_addr, pend_isvector, busy, in_ready} !== {1'b1, 4'd3, 1'b1, 1'b1, (i == L - 1)}) begin
            n_fail++; $display("FAIL vec_pend %0d: got pv=%b pa=%0d pvec=%b busy=%b ready=%b required 1 3 1 1 %b",
                               i, pend_valid, pend_addr, pend_isvector, busy, in_ready, (i == L - 1));
         end
         tick();
      end
      n_chk++;
      if ({busy, pend_valid} !== 2'b00) begin
         n_fail++; $display("FAIL vec_done: got busy=%b pv=%b required 0 0", busy, pend_valid);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      in_valid = 1'b1; in_isvector = 1'b1; in_addr = 4'd6; in_mask = 4'hF;
      in_data = {24'd13, 24'd12, 24'd11, 24'd10};
      tick();
      in_isvector = 1'b0; in_addr = 4'd7; in_mask = 4'h0; in_data = {72'd0, 24'h000055};
      for (int i = 0; i < L; i++) begin
         n_chk++;
         if ({we3, wa3, wd3, lane, busy, in_ready} !== {1'b1, 4'd6, 24'(10 + i), LW'(i), 1'b1, (i == L - 1)}) begin
            n_fail++; $display("FAIL b2b_vec %0d: got we3=%b wa3=%0d wd3=%0d lane=%0d busy=%b ready=%b required 1 6 %0d %0d 1 %b",
                               i, we3, wa3, wd3, lane, busy, in_ready, 10 + i, i, (i == L - 1));
         end
         tick();
      end
      in_valid = 1'b0;
      n_chk++;
      if ({we3, wa3, wd3, isvector, lane, busy, pend_addr} !== {1'b1, 4'd7, 24'h55, 1'b0, 2'd0, 1'b1, 4'd7}) begin
         n_fail++; $display("FAIL b2b_scalar: got we3=%b wa3=%0d wd3=%h vec=%b lane=%0d busy=%b pa=%0d required 1 7 55 0 0 1 7",
                            we3, wa3, wd3, isvector, lane, busy, pend_addr);
      end
      tick();
      n_chk++;
      if ({busy, we3} !== 2'b00) begin
         n_fail++; $display("FAIL b2b_done: got busy=%b we3=%b required 0 0", busy, we3);
      end
   endtask

   initial begin
      test_reset();
      test_scalar();
      test_pc_protect();
      test_vector_mask();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
